// File: rtl/alu_pkg.sv
// ALU command encodings and arbiter FSM state shared by
// the arbiter, its picker and anything driving the ALU.
package alu_pkg;

    typedef logic [2:0] alu_cmd_t;

    localparam alu_cmd_t ALU_ADD  = 3'b000;
    localparam alu_cmd_t ALU_LSL  = 3'b001;
    localparam alu_cmd_t ALU_MOVF = 3'b010;
    localparam alu_cmd_t ALU_XOR  = 3'b011;
    localparam alu_cmd_t ALU_MOV  = 3'b100;
    localparam alu_cmd_t ALU_LSR  = 3'b101;
    localparam alu_cmd_t ALU_SUB  = 3'b110;
    localparam alu_cmd_t ALU_CMP  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

endpackage

// File: rtl/alu_arb_if.sv
// Request/response bundle between the requesters (master)
// and the shared-ALU arbiter (slave).
interface alu_arb_if #(
    parameter int NREQ = 2
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [3*NREQ-1:0] req_cmd;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;

    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [7:0]        resp_rslt;
    logic              resp_flag;
    logic              resp_ready;

    modport master (
        output req_valid,
        output req_cmd,
        output req_a,
        output req_b,
        input  req_ready,
        input  resp_valid,
        input  resp_id,
        input  resp_rslt,
        input  resp_flag,
        output resp_ready
    );

    modport slave (
        input  req_valid,
        input  req_cmd,
        input  req_a,
        input  req_b,
        output req_ready,
        output resp_valid,
        output resp_id,
        output resp_rslt,
        output resp_flag,
        input  resp_ready
    );

endinterface

// File: rtl/alu_arb_rr_pick.sv
// Combinational round-robin picker: first set request bit
// at or above ptr, wrapping at NREQ.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [IDW-1:0] pos;

    // Scan farthest-first so the closest match to ptr wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = IDW'((int'(ptr) + k) % NREQ);
            if (req[pos]) begin
                idx = pos;
                any = 1'b1;
            end
        end
        gnt = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/alu_arb.sv
// Round-robin sharing of one combinational 8-bit ALU; one
// operation in flight, operands and result registered.
module alu_arb
    import alu_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic        clk,
    input  logic        reset,
    alu_arb_if.slave    bus,
    output alu_cmd_t    alu_cmd,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_rslt,
    input  logic        alu_flag,
    output logic [15:0] ops_done
);

    localparam int IDW = $clog2(NREQ);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    alu_cmd_t       cmd_q, cmd_d;
    logic [7:0]     a_q, a_d;
    logic [7:0]     b_q, b_d;
    logic           resp_valid_q, resp_valid_d;
    logic [IDW-1:0] resp_id_q, resp_id_d;
    logic [7:0]     rslt_q, rslt_d;
    logic           flag_q, flag_d;
    logic [15:0]    ops_q, ops_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;
    alu_cmd_t        sel_cmd;
    logic [7:0]      sel_a;
    logic [7:0]      sel_b;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req (bus.req_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    always_comb begin
        sel_cmd = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_cmd = bus.req_cmd[3*i +: 3];
                sel_a   = bus.req_a[8*i +: 8];
                sel_b   = bus.req_b[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (gnt_any) state_d = EXEC;
            EXEC: state_d = RESP;
            RESP: if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        cmd_d        = cmd_q;
        a_d          = a_q;
        b_d          = b_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        rslt_d       = rslt_q;
        flag_d       = flag_q;
        ops_d        = ops_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    cmd_d   = sel_cmd;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    owner_d = gnt_idx;
                    if (gnt_idx == IDW'(NREQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = gnt_idx + 1'b1;
                    end
                end
            end
            EXEC: begin
                rslt_d       = alu_rslt;
                flag_d       = alu_flag;
                resp_id_d    = owner_q;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    ops_d        = ops_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            cmd_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            rslt_q       <= '0;
            flag_q       <= 1'b0;
            ops_q        <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            cmd_q        <= cmd_d;
            a_q          <= a_d;
            b_q          <= b_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            rslt_q       <= rslt_d;
            flag_q       <= flag_d;
            ops_q        <= ops_d;
        end
    end

    // Strobe is masked while reset is high so nothing leaves
    // a requester believing it was accepted.
    always_comb begin
        bus.req_ready  = (state_q == IDLE && !reset) ? gnt : '0;
        bus.resp_valid = resp_valid_q;
        bus.resp_id    = resp_id_q;
        bus.resp_rslt  = rslt_q;
        bus.resp_flag  = flag_q;
        alu_cmd        = cmd_q;
        alu_a          = a_q;
        alu_b          = b_q;
        ops_done       = ops_q;
    end

endmodule

// File: tb/tb_alu_arb.sv
// Randomized and directed bench for alu_arb with a
// transaction-level reference model and a behavioural ALU.
module tb_alu_arb;
    import alu_pkg::*;

    localparam int NREQ = 2;

    logic        clk;
    logic        reset;
    alu_cmd_t    alu_cmd;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_rslt;
    logic        alu_flag;
    logic [15:0] ops_done;

    alu_arb_if #(.NREQ(NREQ)) bus ();

    alu_arb #(.NREQ(NREQ)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .alu_cmd  (alu_cmd),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_rslt (alu_rslt),
        .alu_flag (alu_flag),
        .ops_done (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] alu_fn(logic [2:0] c, logic [7:0] a, logic [7:0] b);
        logic [8:0] r;
        case (c)
            ALU_ADD:  r = {1'b0, a} + {1'b0, b};
            ALU_LSL:  r = {a[7], a[6:0], 1'b0};
            ALU_MOVF: r = {1'b0, b};
            ALU_XOR:  r = {1'b0, a ^ b};
            ALU_MOV:  r = {1'b0, a};
            ALU_LSR:  r = {a[0], 1'b0, a[7:1]};
            ALU_SUB:  r = {a < b, a - b};
            default:  r = {a == b, a - b};
        endcase
        return r;
    endfunction

    always_comb {alu_flag, alu_rslt} = alu_fn(alu_cmd, alu_a, alu_b);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stimulus state
    int         cyc = 0;
    logic       d_reset = 1'b1;
    logic [NREQ-1:0] d_valid = '0;
    logic [2:0] d_cmd [NREQ];
    logic [7:0] d_a   [NREQ];
    logic [7:0] d_b   [NREQ];
    logic       d_rr = 1'b0;
    bit         hold = 1'b0;

    // Reference model state
    bit          armed = 1'b0;
    bit          inflight = 1'b0;
    int          t_acc = 0;
    int          m_ptr = 0;
    int          cur_id = 0;
    logic [2:0]  cur_cmd = '0;
    logic [7:0]  cur_a = '0, cur_b = '0;
    logic [15:0] m_ops = '0;
    logic [2:0]  e_cmd = '0;
    logic [7:0]  e_a = '0, e_b = '0;
    int          e_id = 0;
    logic [7:0]  e_rslt = '0;
    logic        e_flag = 1'b0;

    // Observations for directed checks
    int         g_id [$];
    int         g_cyc [$];
    logic [7:0] o_rslt [NREQ];
    logic       o_flag [NREQ];
    int         o_cyc = 0;

    task automatic set_op(int i, logic [2:0] c, logic [7:0] a, logic [7:0] b);
        d_valid[i] = 1'b1;
        d_cmd[i] = c;
        d_a[i] = a;
        d_b[i] = b;
    endtask

    task automatic monitor();
        logic [NREQ-1:0] exp_rdy;
        int   g;
        bit   e_rv;
        logic [8:0] r;
        exp_rdy = '0;
        g = -1;
        if (!inflight && !d_reset) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (d_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        if (inflight && cyc == t_acc + 2) begin
            r = alu_fn(cur_cmd, cur_a, cur_b);
            e_rslt = r[7:0];
            e_flag = r[8];
            e_id = cur_id;
        end
        e_rv = inflight && (cyc >= t_acc + 2);
        if (armed) begin
            check("req_ready", bus.req_ready, exp_rdy);
            check("resp_valid", bus.resp_valid, e_rv);
            check("resp_id", bus.resp_id, e_id);
            check("resp_rslt", bus.resp_rslt, e_rslt);
            check("resp_flag", bus.resp_flag, e_flag);
            check("alu_cmd", alu_cmd, e_cmd);
            check("alu_a", alu_a, e_a);
            check("alu_b", alu_b, e_b);
            check("ops_done", ops_done, m_ops);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_ready[i] === 1'b1) begin
                g_id.push_back(i);
                g_cyc.push_back(cyc);
            end
        end
        if (bus.resp_valid === 1'b1 && d_rr) begin
            o_rslt[bus.resp_id] = bus.resp_rslt;
            o_flag[bus.resp_id] = bus.resp_flag;
            o_cyc = cyc;
        end
        if (d_reset) begin
            armed = 1'b1;
            inflight = 1'b0;
            m_ptr = 0;
            m_ops = '0;
            e_cmd = '0; e_a = '0; e_b = '0;
            e_id = 0; e_rslt = '0; e_flag = 1'b0;
        end else if (armed) begin
            if (e_rv && d_rr) begin
                inflight = 1'b0;
                m_ops = m_ops + 16'd1;
            end else if (g >= 0) begin
                inflight = 1'b1;
                t_acc = cyc;
                cur_id = g;
                cur_cmd = d_cmd[g]; cur_a = d_a[g]; cur_b = d_b[g];
                e_cmd = d_cmd[g]; e_a = d_a[g]; e_b = d_b[g];
                m_ptr = (g + 1) % NREQ;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_ready[i] === 1'b1 && !hold) d_valid[i] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        reset = d_reset;
        bus.resp_ready = d_rr;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i] = d_valid[i];
            bus.req_cmd[3*i +: 3] = d_cmd[i];
            bus.req_a[8*i +: 8] = d_a[i];
            bus.req_b[8*i +: 8] = d_b[i];
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic drain(int n);
        hold = 1'b0;
        d_valid = '0;
        d_rr = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        int last;
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_cmd = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            d_cmd[i] = '0; d_a[i] = '0; d_b[i] = '0;
            o_rslt[i] = '0; o_flag[i] = 1'b0;
        end

        repeat (3) step();
        d_reset = 1'b0;
        drain(2);

        // Single ADD from requester 0
        g_id.delete(); g_cyc.delete();
        set_op(0, ALU_ADD, 8'h7F, 8'h01);
        repeat (5) step();
        last = (g_id.size() > 0) ? g_id[0] : -1;
        check("add_grant_id", last, 0);
        check("add_latency", o_cyc - ((g_cyc.size() > 0) ? g_cyc[0] : 0), 2);
        check("add_rslt", o_rslt[0], 8'h80);
        check("add_flag", o_flag[0], 1'b0);
        check("add_ops", ops_done, 1);

        // SUB from requester 1
        g_id.delete(); g_cyc.delete();
        set_op(1, ALU_SUB, 8'h03, 8'h05);
        repeat (5) step();
        last = (g_id.size() > 0) ? g_id[0] : -1;
        check("sub_grant_id", last, 1);
        check("sub_rslt", o_rslt[1], 8'hFE);
        check("sub_flag", o_flag[1], 1'b1);

        // Both held valid from reset
        d_reset = 1'b1;
        hold = 1'b1;
        set_op(0, ALU_XOR, 8'hAA, 8'h0F);
        set_op(1, ALU_CMP, 8'h42, 8'h42);
        step();
        d_reset = 1'b0;
        g_id.delete(); g_cyc.delete();
        repeat (12) step();
        drain(3);
        check("cont_ngrants", g_id.size(), 4);
        if (g_id.size() == 4) begin
            for (int k = 0; k < 4; k++) check("cont_order", g_id[k], k % 2);
            for (int k = 1; k < 4; k++) check("cont_gap", g_cyc[k] - g_cyc[k-1], 3);
        end
        check("cont_rslt0", o_rslt[0], 8'hA5);
        check("cont_flag0", o_flag[0], 1'b0);
        check("cont_rslt1", o_rslt[1], 8'h00);
        check("cont_flag1", o_flag[1], 1'b1);

        // Response back-pressure
        d_rr = 1'b0;
        set_op(0, ALU_LSL, 8'h81, 8'h01);
        step();
        set_op(1, ALU_ADD, 8'h01, 8'h02);
        repeat (7) step();
        check("bp_valid", bus.resp_valid, 1'b1);
        check("bp_rslt", bus.resp_rslt, 8'h02);
        check("bp_flag", bus.resp_flag, 1'b1);
        check("bp_ready", bus.req_ready, 0);
        d_rr = 1'b1;
        repeat (5) step();
        check("bp_done_rslt", o_rslt[0], 8'h02);
        check("bp_next_rslt", o_rslt[1], 8'h03);
        drain(2);

        // Reset while in EXEC
        set_op(0, ALU_MOV, 8'h33, 8'h00);
        step();
        d_reset = 1'b1;
        set_op(0, ALU_MOV, 8'h44, 8'h00);
        set_op(1, ALU_MOV, 8'h55, 8'h00);
        step();
        d_reset = 1'b0;
        g_id.delete(); g_cyc.delete();
        step();
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_ops", ops_done, 0);
        check("rst_alu_a", alu_a, 8'h00);
        last = (g_id.size() > 0) ? g_id[0] : -1;
        check("rst_first_grant", last, 0);
        drain(8);

        // ops_done wrap
        @(posedge clk);
        cyc++;
        #1;
        force dut.ops_q = 16'hFFFF;
        @(negedge clk);
        release dut.ops_q;
        m_ops = 16'hFFFF;
        set_op(1, ALU_LSR, 8'h81, 8'h00);
        repeat (4) step();
        check("wrap_ops", ops_done, 16'h0000);
        drain(2);

        // Randomized traffic
        repeat (3000) begin
            d_reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!d_valid[i]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_op(i, 3'($urandom), 8'($urandom), 8'($urandom));
                end else if ($urandom_range(0, 9) == 0) begin
                    d_valid[i] = 1'b0;
                end
            end
            d_rr = ($urandom_range(0, 3) != 0);
            step();
        end
        d_reset = 1'b0;
        drain(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
